conv_window_scheduler: RTL and testbench

- Sequences the 5x5 convolution datapath (conv) over one input feature map: fetches pixels from the image memory, assembles each sliding window, fires conv with a start/finish handshake and writes each result to output memory.
- Valid convolution, stride 1, single filter. The filter is held externally and is not touched by this block.
- Sits between the layer controller (start/done) and the conv unit plus its feature-map memories.

---
 rtl/conv_window_scheduler.sv | 188 ++++++++++++++++++
 tb/tb_conv_window_scheduler.sv | 184 ++++++++++++++++++
 2 files changed

// File: rtl/conv_window_scheduler.sv
// rtl/conv_window_scheduler.sv - sliding-window fetch/convolve/write sequencer for a KxK conv unit
module conv_window_scheduler #(
    parameter int IMG_W  = 32,
    parameter int IMG_H  = 32,
    parameter int K      = 5,
    parameter int DATA_W = 16,
    parameter int ADDR_W = 16
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    output logic                  busy,
    output logic                  done,
    output logic [ADDR_W-1:0]     in_addr,
    output logic                  in_re,
    input  logic [DATA_W-1:0]     in_data,
    output logic [K*K*DATA_W-1:0] window_flat,
    output logic                  conv_start,
    input  logic                  conv_finish,
    input  logic [DATA_W-1:0]     conv_result,
    output logic [ADDR_W-1:0]     out_addr,
    output logic [DATA_W-1:0]     out_data,
    output logic                  out_we
);

    localparam int CW = $clog2(K*K+1);
    localparam logic [CW-1:0]     LP_KK    = CW'(K*K);
    localparam logic [CW-1:0]     LP_K     = CW'(K);
    localparam logic [CW-1:0]     LP_KM1   = CW'(K-1);
    localparam logic [ADDR_W-1:0] LP_W     = ADDR_W'(IMG_W);
    localparam logic [ADDR_W-1:0] LP_OW    = ADDR_W'(IMG_W-K+1);
    localparam logic [ADDR_W-1:0] LP_OXMAX = ADDR_W'(IMG_W-K);
    localparam logic [ADDR_W-1:0] LP_OYMAX = ADDR_W'(IMG_H-K);

    // The whole input map must be addressable.
    if (64'(IMG_W) * 64'(IMG_H) > (64'd1 << ADDR_W)) begin : g_addr_chk
        $error("conv_window_scheduler: IMG_W*IMG_H does not fit in ADDR_W");
    end

    typedef enum logic [2:0] {
        S_IDLE, S_LOAD_FULL, S_LOAD_COL, S_CONV, S_WRITE, S_DONE
    } state_t;

    state_t             r_state;
    logic [ADDR_W-1:0]  r_ox, r_oy;
    logic [CW-1:0]      r_cnt;       // cycles spent in the current load state
    logic [CW-1:0]      r_rr, r_rc;  // window offset of the read currently on in_addr
    logic               r_pend;      // a read issued last cycle returns data this cycle
    logic [CW-1:0]      r_pr, r_pc;  // window offset that returning datum belongs to
    logic [DATA_W-1:0]  r_win [K*K];

    logic [CW-1:0]      w_nr, w_nc;
    logic [CW-1:0]      w_last;

    function automatic logic [ADDR_W-1:0] f_addr(input logic [ADDR_W-1:0] y,
                                                 input logic [ADDR_W-1:0] x);
        return y * LP_W + x;
    endfunction

    for (genvar gi = 0; gi < K*K; gi++) begin : g_flat
        assign window_flat[gi*DATA_W +: DATA_W] = r_win[gi];
    end

    // Next read offset: rows advance fastest, then columns (column-major fill).
    always_comb begin
        w_nr   = r_rr + CW'(1);
        w_nc   = r_rc;
        w_last = (r_state == S_LOAD_FULL) ? LP_KK : LP_K;
        if (r_rr == LP_KM1) begin
            w_nr = '0;
            w_nc = r_rc + CW'(1);
        end
    end

    // Main sequencer: fetch, window assembly, conv handshake and result write.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state    <= S_IDLE;
            busy       <= 1'b0;
            done       <= 1'b0;
            in_re      <= 1'b0;
            in_addr    <= '0;
            conv_start <= 1'b0;
            out_addr   <= '0;
            out_data   <= '0;
            out_we     <= 1'b0;
            r_ox       <= '0;
            r_oy       <= '0;
            r_cnt      <= '0;
            r_rr       <= '0;
            r_rc       <= '0;
            r_pend     <= 1'b0;
            r_pr       <= '0;
            r_pc       <= '0;
            for (int i = 0; i < K*K; i++) r_win[i] <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_state <= S_LOAD_FULL;
                        busy    <= 1'b1;
                        in_re   <= 1'b1;
                        in_addr <= '0;
                        r_ox    <= '0;
                        r_oy    <= '0;
                        r_rr    <= '0;
                        r_rc    <= '0;
                        r_cnt   <= '0;
                    end
                end
                S_LOAD_FULL, S_LOAD_COL: begin
                    if (r_pend) begin
                        for (int r = 0; r < K; r++) begin
                            if (r == int'(r_pr)) begin
                                if (r_state == S_LOAD_FULL) begin
                                    for (int c = 0; c < K; c++)
                                        if (c == int'(r_pc)) r_win[r*K+c] <= in_data;
                                end else begin
                                    for (int c = 0; c < K-1; c++)
                                        r_win[r*K+c] <= r_win[r*K+c+1];
                                    r_win[r*K+K-1] <= in_data;
                                end
                            end
                        end
                    end
                    r_pend <= in_re;
                    r_pr   <= r_rr;
                    r_pc   <= r_rc;
                    if (r_cnt == w_last) begin
                        in_re      <= 1'b0;
                        conv_start <= 1'b1;
                        r_state    <= S_CONV;
                    end else begin
                        r_cnt <= r_cnt + CW'(1);
                        if (r_cnt + CW'(1) < w_last) begin
                            r_rr    <= w_nr;
                            r_rc    <= w_nc;
                            in_re   <= 1'b1;
                            in_addr <= f_addr(r_oy + ADDR_W'(w_nr), r_ox + ADDR_W'(w_nc));
                        end else begin
                            in_re <= 1'b0;
                        end
                    end
                end
                S_CONV: begin
                    if (conv_finish) begin
                        conv_start <= 1'b0;
                        out_data   <= conv_result;
                        out_addr   <= r_oy * LP_OW + r_ox;
                        out_we     <= 1'b1;
                        r_state    <= S_WRITE;
                    end
                end
                S_WRITE: begin
                    out_we <= 1'b0;
                    r_rr   <= '0;
                    r_cnt  <= '0;
                    if (r_ox < LP_OXMAX) begin
                        r_ox    <= r_ox + ADDR_W'(1);
                        r_rc    <= LP_KM1;
                        in_re   <= 1'b1;
                        in_addr <= f_addr(r_oy, r_ox + ADDR_W'(K));
                        r_state <= S_LOAD_COL;
                    end else begin
                        r_ox <= '0;
                        if (r_oy < LP_OYMAX) begin
                            r_oy    <= r_oy + ADDR_W'(1);
                            r_rc    <= '0;
                            in_re   <= 1'b1;
                            in_addr <= f_addr(r_oy + ADDR_W'(1), '0);
                            r_state <= S_LOAD_FULL;
                        end else begin
                            done    <= 1'b1;
                            r_state <= S_DONE;
                        end
                    end
                end
                S_DONE: begin
                    done    <= 1'b0;
                    busy    <= 1'b0;
                    r_state <= S_IDLE;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_conv_window_scheduler.sv
// tb/tb_conv_window_scheduler.sv - scoreboard bench for conv_window_scheduler on a 6x6 map
module tb_conv_window_scheduler;
    localparam int W = 6, H = 6, K = 5, DW = 16, AW = 16;
    localparam int OW = W - K + 1, OH = H - K + 1, NO = OW * OH;
    localparam int WB = K * K * DW;

    logic          clk = 1'b0, rst_n = 1'b0, start = 1'b0;
    logic          busy, done, in_re, conv_start, conv_finish, out_we;
    logic [AW-1:0] in_addr, out_addr;
    logic [DW-1:0] in_data = '0, conv_result, out_data;
    logic [WB-1:0] window_flat;

    always #5 clk = ~clk;

    conv_window_scheduler #(.IMG_W(W), .IMG_H(H), .K(K), .DATA_W(DW), .ADDR_W(AW)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .busy(busy), .done(done),
        .in_addr(in_addr), .in_re(in_re), .in_data(in_data), .window_flat(window_flat),
        .conv_start(conv_start), .conv_finish(conv_finish), .conv_result(conv_result),
        .out_addr(out_addr), .out_data(out_data), .out_we(out_we)
    );

    // Image memory and conv unit models
    logic [DW-1:0] mem [W*H];
    int fdelay = 1;
    int fcnt = 0;
    always @(posedge clk) if (in_re) in_data <= mem[in_addr];
    always @(posedge clk) fcnt <= conv_start ? fcnt + 1 : 0;
    assign conv_finish = conv_start && (fcnt >= fdelay);
    always_comb begin
        conv_result = '0;
        for (int i = 0; i < K*K; i++) conv_result = conv_result + window_flat[i*DW +: DW];
    end

    int checks = 0, passes = 0;
    task automatic chk(input string nm, input logic [WB-1:0] act, input logic [WB-1:0] exp);
        checks++;
        if (act === exp) passes++;
        else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    endtask

    // Scoreboard queues
    logic [AW-1:0]      q_rd  [$];
    logic [WB-1:0]      q_win [$];
    logic [AW+DW-1:0]   q_out [$];

    task automatic build_model();
        logic [WB-1:0] w;
        logic [DW-1:0] s;
        q_rd.delete(); q_win.delete(); q_out.delete();
        for (int oy = 0; oy < OH; oy++)
            for (int ox = 0; ox < OW; ox++) begin
                if (ox == 0) begin
                    for (int c = 0; c < K; c++)
                        for (int r = 0; r < K; r++) q_rd.push_back(AW'((oy + r) * W + c));
                end else begin
                    for (int r = 0; r < K; r++) q_rd.push_back(AW'((oy + r) * W + ox + K - 1));
                end
                s = '0;
                for (int r = 0; r < K; r++)
                    for (int c = 0; c < K; c++) begin
                        w[(r*K+c)*DW +: DW] = mem[(oy + r) * W + ox + c];
                        s = s + mem[(oy + r) * W + ox + c];
                    end
                q_win.push_back(w);
                q_out.push_back({AW'(oy * OW + ox), s});
            end
    endtask

    // Monitor
    int cs_len = 0, conv_idx = 0, busy_cyc = 0, done_cnt = 0, wr_cnt = 0;
    always @(negedge clk) begin
        if (in_re) begin
            chk("read_expected", q_rd.size() != 0, 1);
            if (q_rd.size() != 0) chk("read_addr", in_addr, q_rd.pop_front());
        end
        if (conv_start) begin
            cs_len++;
            if (cs_len == 1) begin
                conv_idx++;
                chk("win_at_conv_entry", window_flat, (q_win.size() != 0) ? q_win[0] : 'x);
            end
            if (conv_finish) begin
                chk("conv_start_len", cs_len, fdelay + 1);
                chk("window_expected", q_win.size() != 0, 1);
                if (q_win.size() != 0) chk("win_at_finish", window_flat, q_win.pop_front());
            end
        end else begin
            cs_len = 0;
        end
        if (out_we) begin
            wr_cnt++;
            chk("write_expected", q_out.size() != 0, 1);
            if (q_out.size() != 0) chk("write_addr_data", {out_addr, out_data}, q_out.pop_front());
        end
        if (busy) busy_cyc++;
        if (done) done_cnt++;
    end

    task automatic check_zero(input string tag);
        chk({tag, "_busy"}, busy, 0);
        chk({tag, "_done"}, done, 0);
        chk({tag, "_in_re"}, in_re, 0);
        chk({tag, "_conv_start"}, conv_start, 0);
        chk({tag, "_out_we"}, out_we, 0);
        chk({tag, "_in_addr"}, in_addr, 0);
        chk({tag, "_out_addr"}, out_addr, 0);
        chk({tag, "_out_data"}, out_data, 0);
        chk({tag, "_window"}, window_flat, 0);
    endtask

    task automatic fill(input bit rnd);
        for (int i = 0; i < W*H; i++) mem[i] = rnd ? DW'($urandom) : DW'(i);
    endtask

    task automatic start_map(input int f);
        fdelay = f;
        build_model();
        busy_cyc = 0; done_cnt = 0; wr_cnt = 0; conv_idx = 0;
        @(posedge clk); #1 start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
    endtask

    task automatic run_map(input int f, input bit junk);
        int n;
        start_map(f);
        n = 0;
        while (!done && n < 2000) begin
            start = junk && ($urandom_range(0, 5) == 0);
            @(posedge clk); #1;
            n++;
        end
        chk("done_seen", n < 2000, 1);
        start = junk;
        @(posedge clk); #1;
        start = 1'b0;
        chk("idle_after_done", busy, 0);
        @(posedge clk); #1;
        chk("stays_idle", busy, 0);
        chk("done_count", done_cnt, 1);
        chk("write_count", wr_cnt, NO);
        chk("busy_cycles", busy_cyc, OH * ((K*K + 1) + (W - K) * (K + 1)) + NO * (f + 2) + 1);
        chk("reads_drained", q_rd.size(), 0);
        chk("writes_drained", q_out.size(), 0);
    endtask

    initial begin
        int n;
        repeat (2) @(posedge clk);
        #1;
        check_zero("reset");
        rst_n = 1'b1;

        fill(1'b0); run_map(1, 1'b0);
        fill(1'b1); run_map(7, 1'b1);

        // Abort with reset in the third window's CONV
        fill(1'b1);
        start_map(3);
        n = 0;
        while (!(conv_idx == 3 && conv_start) && n < 2000) begin
            @(posedge clk); #1;
            n++;
        end
        chk("third_conv_seen", n < 2000, 1);
        rst_n = 1'b0;
        @(posedge clk); #1;
        check_zero("abort");
        chk("writes_before_abort", wr_cnt, 2);
        rst_n = 1'b1;
        q_rd.delete(); q_win.delete(); q_out.delete();
        repeat (3) @(posedge clk);
        #1;
        chk("no_activity_after_abort", {in_re, conv_start, out_we, busy}, 0);

        fill(1'b0); run_map(0, 1'b0);
        for (int t = 0; t < 4; t++) begin
            fill(1'b1);
            run_map($urandom_range(0, 4), 1'b1);
        end

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end
endmodule
